// File: rtl/clkgen_prog_interface.sv
// Serialises LoadD / LoadM / Go onto DCM_CLKGEN PROGEN/PROGDATA and waits for PROGDONE.
// Optional PROGDONE timeout is enabled by defining CLKGEN_PROG_TIMEOUT_EN.
module clkgen_prog_interface #(
    parameter logic [7:0]  DEFAULT_MUL_M1 = 8'd1,
    parameter logic [7:0]  DEFAULT_DIV_M1 = 8'd1,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] mul_i,
    input  logic [7:0] div_i,
    input  logic       load_i,
    output logic [7:0] mul_o,
    output logic [7:0] div_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       progen_o,
    output logic       progdata_o,
    input  logic       progdone_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOADD, S_GAP1, S_LOADM, S_GAP2, S_GO, S_WAIT
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [9:0]  r_shift;
    logic [7:0]  r_mul_sh;
    logic [7:0]  r_div_sh;
    logic [7:0]  r_mul;
    logic [7:0]  r_div;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_progen;
    logic        r_progdata;

`ifdef CLKGEN_PROG_TIMEOUT_EN
    logic [15:0] r_tmo;
`else
    logic        w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

    // Control path: state, bit counter and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_progen   <= 1'b0;
            r_progdata <= 1'b0;
            r_mul      <= DEFAULT_MUL_M1;
            r_div      <= DEFAULT_DIV_M1;
`ifdef CLKGEN_PROG_TIMEOUT_EN
            r_tmo      <= 16'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_i) begin
                        if (mul_i == 8'd0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err      <= 1'b0;
                            r_state    <= S_LOADD;
                            r_busy     <= 1'b1;
                            r_progen   <= 1'b1;
                            r_progdata <= 1'b1;
                            r_cnt      <= 4'd9;
                        end
                    end
                end
                S_LOADD: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= S_GAP1;
                        r_progen   <= 1'b0;
                        r_progdata <= 1'b0;
                        r_cnt      <= 4'd1;
                    end else begin
                        r_progdata <= r_shift[1];
                        r_cnt      <= r_cnt - 4'd1;
                    end
                end
                S_GAP1: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= S_LOADM;
                        r_progen   <= 1'b1;
                        r_progdata <= 1'b1;
                        r_cnt      <= 4'd9;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_LOADM: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= S_GAP2;
                        r_progen   <= 1'b0;
                        r_progdata <= 1'b0;
                        r_cnt      <= 4'd1;
                    end else begin
                        r_progdata <= r_shift[1];
                        r_cnt      <= r_cnt - 4'd1;
                    end
                end
                S_GAP2: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= S_GO;
                        r_progen   <= 1'b1;
                        r_progdata <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_GO: begin
                    r_state    <= S_WAIT;
                    r_progen   <= 1'b0;
                    r_progdata <= 1'b0;
`ifdef CLKGEN_PROG_TIMEOUT_EN
                    r_tmo      <= 16'd0;
`endif
                end
                S_WAIT: begin
                    // PROGDONE takes priority over a coincident timeout.
                    if (progdone_i) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_mul   <= r_mul_sh;
                        r_div   <= r_div_sh;
`ifdef CLKGEN_PROG_TIMEOUT_EN
                    end else if (r_tmo == TIMEOUT_CYCLES - 16'd1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
`endif
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_progen   <= 1'b0;
                    r_progdata <= 1'b0;
                end
            endcase
        end
    end

    // Data path: shadow registers and command shift register, no reset needed.
    always_ff @(posedge clk_i) begin
        case (r_state)
            S_IDLE: begin
                if (load_i && (mul_i != 8'd0)) begin
                    r_mul_sh <= mul_i;
                    r_div_sh <= div_i;
                    r_shift  <= {div_i, 2'b01};
                end
            end
            S_GAP1: begin
                if (r_cnt == 4'd0) begin
                    r_shift <= {r_mul_sh, 2'b11};
                end
            end
            S_LOADD, S_LOADM: begin
                r_shift <= r_shift >> 1;
            end
            default: begin
            end
        endcase
    end

    assign mul_o      = r_mul;
    assign div_o      = r_div;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign progen_o   = r_progen;
    assign progdata_o = r_progdata;

endmodule

// File: tb/tb_clkgen_prog_interface.sv
// Directed bench for clkgen_prog_interface; covers the timeout variant when CLKGEN_PROG_TIMEOUT_EN is defined.
module tb_clkgen_prog_interface;

`ifdef CLKGEN_PROG_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'd100;
`else
    localparam logic [15:0] TMO = 16'd65535;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] mul_i;
    logic [7:0] div_i;
    logic       load_i;
    logic [7:0] mul_o;
    logic [7:0] div_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic       progen_o;
    logic       progdata_o;
    logic       progdone_i;

    int total = 0;
    int bad   = 0;

    clkgen_prog_interface #(
        .DEFAULT_MUL_M1(8'd1),
        .DEFAULT_DIV_M1(8'd1),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .mul_i      (mul_i),
        .div_i      (div_i),
        .load_i     (load_i),
        .mul_o      (mul_o),
        .div_o      (div_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .progen_o   (progen_o),
        .progdata_o (progdata_o),
        .progdone_i (progdone_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Records progen/progdata over cycles T+1..T+25; optionally pulses load_i at cycle T+inj.
    task automatic capture(input int inj, output logic [24:0] en, output logic [24:0] dat);
        for (int i = 0; i < 25; i++) begin
            en[i]  = progen_o;
            dat[i] = progdata_o;
            load_i = (i + 1 == inj);
            tick();
        end
        load_i = 1'b0;
    endtask

    logic [24:0] en_v;
    logic [24:0] dat_v;
    logic        flag;

    initial begin
        reset      = 1'b1;
        load_i     = 1'b0;
        mul_i      = 8'd0;
        div_i      = 8'd0;
        progdone_i = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_mul", 32'(mul_o), 32'd1);
        check("rst_div", 32'(div_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_prog", 32'({progen_o, progdata_o}), 32'd0);

        // M=5, D=3 with PROGDONE at T+30
        mul_i = 8'd4; div_i = 8'd2; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check("t1_busy", 32'(busy_o), 32'd1);
        capture(0, en_v, dat_v);
        check("t1_en", 32'(en_v), 32'h13FF3FF);
        check("t1_data", 32'(dat_v), 32'h1013009);
        check("t1_wait_busy", 32'(busy_o), 32'd1);
        check("t1_wait_en", 32'(progen_o), 32'd0);
        repeat (4) tick();
        check("t1_nodone", 32'(done_o), 32'd0);
        progdone_i = 1'b1;
        tick();
        progdone_i = 1'b0;
        check("t1_done", 32'(done_o), 32'd1);
        check("t1_busy0", 32'(busy_o), 32'd0);
        check("t1_mul", 32'(mul_o), 32'd4);
        check("t1_div", 32'(div_o), 32'd2);
        tick();
        check("t1_done_pulse", 32'(done_o), 32'd0);

        // Invalid M rejected
        mul_i = 8'd0; div_i = 8'd3; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check("t2_err", 32'(err_o), 32'd1);
        check("t2_busy", 32'(busy_o), 32'd0);
        check("t2_en", 32'(progen_o), 32'd0);
        check("t2_mul", 32'(mul_o), 32'd4);
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (progen_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) flag = 1'b1;
        end
        check("t2_quiet", 32'(flag), 32'd0);
        check("t2_err_sticky", 32'(err_o), 32'd1);

        // Ignored second load at T+5, PROGDONE at earliest point
        mul_i = 8'd7; div_i = 8'd5; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check("t3_err_clr", 32'(err_o), 32'd0);
        check("t3_busy", 32'(busy_o), 32'd1);
        mul_i = 8'd9; div_i = 8'd9;
        capture(5, en_v, dat_v);
        check("t3_en", 32'(en_v), 32'h13FF3FF);
        check("t3_data", 32'(dat_v), 32'h101F015);
        progdone_i = 1'b1;
        tick();
        progdone_i = 1'b0;
        check("t3_done", 32'(done_o), 32'd1);
        check("t3_busy0", 32'(busy_o), 32'd0);
        check("t3_mul", 32'(mul_o), 32'd7);
        check("t3_div", 32'(div_o), 32'd5);

        // Back-to-back load on first idle cycle, max M and D
        mul_i = 8'd255; div_i = 8'd255; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check("t4_busy", 32'(busy_o), 32'd1);
        check("t4_en1", 32'(progen_o), 32'd1);
        capture(0, en_v, dat_v);
        check("t4_data", 32'(dat_v), 32'h13FF3FD);
        progdone_i = 1'b1;
        tick();
        progdone_i = 1'b0;
        check("t4_mul", 32'(mul_o), 32'd255);
        check("t4_div", 32'(div_o), 32'd255);

        // Reset mid-LOADM
        mul_i = 8'd1; div_i = 8'd0; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        repeat (14) tick();
        check("t5_pre_en", 32'(progen_o), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_en", 32'(progen_o), 32'd0);
        check("t5_data", 32'(progdata_o), 32'd0);
        check("t5_busy", 32'(busy_o), 32'd0);
        check("t5_mul", 32'(mul_o), 32'd1);
        check("t5_div", 32'(div_o), 32'd1);
        check("t5_done", 32'(done_o), 32'd0);
        progdone_i = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done_o !== 1'b0 || busy_o !== 1'b0) flag = 1'b1;
        end
        progdone_i = 1'b0;
        check("t5_progdone_ignored", 32'(flag), 32'd0);

        // PROGDONE never arrives
        mul_i = 8'd2; div_i = 8'd1; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        repeat (25) tick();
        check("t6_wait_busy", 32'(busy_o), 32'd1);
        check("t6_wait_en", 32'(progen_o), 32'd0);
`ifdef CLKGEN_PROG_TIMEOUT_EN
        repeat (99) tick();
        check("t6_pre_busy", 32'(busy_o), 32'd1);
        check("t6_pre_err", 32'(err_o), 32'd0);
        tick();
        check("t6_tmo_busy", 32'(busy_o), 32'd0);
        check("t6_tmo_err", 32'(err_o), 32'd1);
        check("t6_tmo_done", 32'(done_o), 32'd0);
        check("t6_tmo_mul", 32'(mul_o), 32'd1);
        mul_i = 8'd3; div_i = 8'd3; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check("t6_err_clr", 32'(err_o), 32'd0);
        check("t6_reload_busy", 32'(busy_o), 32'd1);
`else
        flag = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            if (busy_o !== 1'b1 || err_o !== 1'b0 || done_o !== 1'b0) flag = 1'b1;
            tick();
        end
        check("t6_hold", 32'(flag), 32'd0);
        check("t6_hold_mul", 32'(mul_o), 32'd1);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_busy", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
